test_uart: RTL and testbench

TEST_UART -- requirements
Module: test_uart

---
 rtl/test_uart_pkg.sv | 19 +
 rtl/fifo.sv | 55 +++++
 rtl/test_uart_core.sv | 186 ++++++++++++++++++
 rtl/test_uart.sv | 88 ++++++++
 tb/tb_test_uart.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/test_uart_pkg.sv
// Shared state encodings, loader patterns and helpers for the dual-channel UART test block.
package test_uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Oversampling counter width, wide enough for two stop bits at 16x.
    localparam int TICK_W   = 6;
    localparam int LOAD_LEN = 4;

    // Byte 0 (least significant) is loaded and sent first.
    localparam logic [31:0] LOAD_FEM = 32'hF00F_AA55;
    localparam logic [31:0] LOAD_M   = 32'h3433_3231;

    function automatic logic [7:0] load_byte(input logic [31:0] pat, input logic [1:0] idx);
        return pat[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic FIFO of 2**AW words with registered full/empty flags; head word shown combinationally.
// Latency: a written word appears at rd_dat the cycle after the write.
// Backpressure: write dropped when full unless a read occurs that cycle; read ignored when empty.
module fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] w_ptr, r_ptr, w_ptr_nxt, r_ptr_nxt;
    logic          wr_en, rd_en;

    assign rd_en     = rd_rdy & ~empty;
    assign wr_en     = wr_vld & (~full | rd_en);
    assign w_ptr_nxt = w_ptr + 1'b1;
    assign r_ptr_nxt = r_ptr + 1'b1;
    assign rd_dat    = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[w_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_en)
                w_ptr <= w_ptr_nxt;
            if (rd_en)
                r_ptr <= r_ptr_nxt;
            // Flags only move on a lone write or a lone read; both together keep the fill level.
            if (wr_en && !rd_en) begin
                empty <= 1'b0;
                full  <= (w_ptr_nxt == r_ptr);
            end else if (rd_en && !wr_en) begin
                full  <= 1'b0;
                empty <= (r_ptr_nxt == w_ptr);
            end
        end
    end

endmodule

// File: rtl/test_uart_core.sv
// One UART channel: TX FIFO -> serializer, deserializer -> RX FIFO; TEST_UART_RX_SYNC_EN adds an rx synchronizer.
// Latency: TX frame starts 1 cycle after a word lands in the TX FIFO; RX byte pushed SB_TICK ticks into the stop bit.
// Backpressure: loader must respect tx_full; a received byte is dropped when the RX FIFO is full.
module uart_core #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            wr_vld,
    input  logic [DBIT-1:0] wr_dat,
    input  logic            rd_rdy,
    input  logic            rx,
    output logic            tx,
    output logic            tx_full,
    output logic            rx_full,
    output logic            rx_empty,
    output logic [DBIT-1:0] rx_dat
);
    import test_uart_pkg::*;

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0] BIT_TICK  = TICK_W'(15);
    localparam logic [TICK_W-1:0] STOP_TICK = TICK_W'(SB_TICK - 1);
    localparam logic [NW-1:0]     N_LAST    = NW'(DBIT - 1);

    logic            rx_in;
    logic            tx_pop, tx_fifo_empty, rx_push;
    logic [DBIT-1:0] tx_fifo_dat;

`ifdef TEST_UART_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], rx};
    end
    assign rx_in = rx_sync[1];
`else
    assign rx_in = rx;
`endif

    fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk(clk), .reset(reset), .wr_vld(wr_vld), .wr_dat(wr_dat), .rd_rdy(tx_pop),
        .rd_dat(tx_fifo_dat), .full(tx_full), .empty(tx_fifo_empty)
    );

    tx_state_t         tx_state, tx_state_nxt;
    logic [TICK_W-1:0] tx_s, tx_s_nxt;
    logic [NW-1:0]     tx_n, tx_n_nxt;
    logic [DBIT-1:0]   tx_b, tx_b_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_s     <= tx_s_nxt;
            tx_n     <= tx_n_nxt;
            tx_b     <= tx_b_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_s_nxt     = tx_s;
        tx_n_nxt     = tx_n;
        tx_b_nxt     = tx_b;
        tx_pop       = 1'b0;
        tx           = 1'b1;
        case (tx_state)
            TX_IDLE: if (!tx_fifo_empty) begin
                tx_pop       = 1'b1;
                tx_b_nxt     = tx_fifo_dat;
                tx_s_nxt     = '0;
                tx_state_nxt = TX_START;
            end
            TX_START: begin
                tx = 1'b0;
                if (tick) begin
                    if (tx_s == BIT_TICK) begin
                        tx_s_nxt     = '0;
                        tx_n_nxt     = '0;
                        tx_state_nxt = TX_DATA;
                    end else
                        tx_s_nxt = tx_s + 1'b1;
                end
            end
            TX_DATA: begin
                tx = tx_b[0];
                if (tick) begin
                    if (tx_s == BIT_TICK) begin
                        tx_s_nxt = '0;
                        tx_b_nxt = tx_b >> 1;
                        if (tx_n == N_LAST)
                            tx_state_nxt = TX_STOP;
                        else
                            tx_n_nxt = tx_n + 1'b1;
                    end else
                        tx_s_nxt = tx_s + 1'b1;
                end
            end
            TX_STOP: if (tick) begin
                if (tx_s == STOP_TICK)
                    tx_state_nxt = TX_IDLE;
                else
                    tx_s_nxt = tx_s + 1'b1;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    rx_state_t         rx_state, rx_state_nxt;
    logic [TICK_W-1:0] rx_s, rx_s_nxt;
    logic [NW-1:0]     rx_n, rx_n_nxt;
    logic [DBIT-1:0]   rx_b, rx_b_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_s     <= rx_s_nxt;
            rx_n     <= rx_n_nxt;
            rx_b     <= rx_b_nxt;
        end
    end

    // Start bit is re-checked mid-bit so a short low glitch falls back to idle.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_s_nxt     = rx_s;
        rx_n_nxt     = rx_n;
        rx_b_nxt     = rx_b;
        rx_push      = 1'b0;
        case (rx_state)
            RX_IDLE: if (!rx_in) begin
                rx_s_nxt     = '0;
                rx_state_nxt = RX_START;
            end
            RX_START: if (tick) begin
                if (rx_s == MID_TICK) begin
                    rx_s_nxt     = '0;
                    rx_n_nxt     = '0;
                    rx_state_nxt = rx_in ? RX_IDLE : RX_DATA;
                end else
                    rx_s_nxt = rx_s + 1'b1;
            end
            RX_DATA: if (tick) begin
                if (rx_s == BIT_TICK) begin
                    rx_s_nxt = '0;
                    rx_b_nxt = {rx_in, rx_b[DBIT-1:1]};
                    if (rx_n == N_LAST)
                        rx_state_nxt = RX_STOP;
                    else
                        rx_n_nxt = rx_n + 1'b1;
                end else
                    rx_s_nxt = rx_s + 1'b1;
            end
            RX_STOP: if (tick) begin
                if (rx_s == STOP_TICK) begin
                    rx_push      = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end else
                    rx_s_nxt = rx_s + 1'b1;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
        .clk(clk), .reset(reset), .wr_vld(rx_push), .wr_dat(rx_b), .rd_rdy(rd_rdy),
        .rd_dat(rx_dat), .full(rx_full), .empty(rx_empty)
    );

endmodule

// File: rtl/test_uart.sv
// Two-channel UART self-test: shared baud tick, 4-byte TX loader per channel, FEM RX head on LEDs; TEST_UART_RX_SYNC_EN adds rx synchronizers.
// Latency: loader writes from the first cycle after reset; LEDs follow the FEM RX FIFO head combinationally.
// Backpressure: loader stalls while tx_full is high; rd_uart pops both RX FIFOs, ignored when empty.
module test_uart #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8,
    parameter int FIFO_W   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rd_uart,
    input  logic rx_fem,
    input  logic rx_m,
    output logic tx_fem,
    output logic tx_m,
    output logic tx_full_fem,
    output logic tx_full_m,
    output logic rx_full_fem,
    output logic rx_full_m,
    output logic rx_empty_fem,
    output logic rx_empty_m,
    output logic led0,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic led5,
    output logic led6,
    output logic led7
);
    import test_uart_pkg::*;

    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;

    assign tick = (baud_cnt == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            baud_cnt <= '0;
        else
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end

    logic [2:0]      ld_cnt_fem, ld_cnt_m;
    logic            ld_vld_fem, ld_vld_m;
    logic [DBIT-1:0] ld_dat_fem, ld_dat_m;

    assign ld_vld_fem = (ld_cnt_fem < 3'(LOAD_LEN)) & ~tx_full_fem;
    assign ld_vld_m   = (ld_cnt_m < 3'(LOAD_LEN)) & ~tx_full_m;
    assign ld_dat_fem = DBIT'(load_byte(LOAD_FEM, ld_cnt_fem[1:0]));
    assign ld_dat_m   = DBIT'(load_byte(LOAD_M, ld_cnt_m[1:0]));

    // Counters park at LOAD_LEN so the loader runs exactly once per reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt_fem <= '0;
            ld_cnt_m   <= '0;
        end else begin
            if (ld_vld_fem)
                ld_cnt_fem <= ld_cnt_fem + 1'b1;
            if (ld_vld_m)
                ld_cnt_m <= ld_cnt_m + 1'b1;
        end
    end

    logic [DBIT-1:0] rx_dat_fem;
    logic [DBIT-1:0] rx_dat_m_unused;  // M channel data has no consumer at this level

    uart_core #(.DBIT(DBIT), .SB_TICK(SB_TICK), .FIFO_W(FIFO_W)) u_fem (
        .clk(clk), .reset(reset), .tick(tick), .wr_vld(ld_vld_fem), .wr_dat(ld_dat_fem),
        .rd_rdy(rd_uart), .rx(rx_fem), .tx(tx_fem), .tx_full(tx_full_fem),
        .rx_full(rx_full_fem), .rx_empty(rx_empty_fem), .rx_dat(rx_dat_fem)
    );

    uart_core #(.DBIT(DBIT), .SB_TICK(SB_TICK), .FIFO_W(FIFO_W)) u_m (
        .clk(clk), .reset(reset), .tick(tick), .wr_vld(ld_vld_m), .wr_dat(ld_dat_m),
        .rd_rdy(rd_uart), .rx(rx_m), .tx(tx_m), .tx_full(tx_full_m),
        .rx_full(rx_full_m), .rx_empty(rx_empty_m), .rx_dat(rx_dat_m_unused)
    );

    logic [7:0] led_dat;
    assign led_dat = rx_empty_fem ? 8'h00 : 8'(rx_dat_fem);
    assign {led7, led6, led5, led4, led3, led2, led1, led0} = led_dat;

endmodule

// File: tb/tb_test_uart.sv
// Loopback bench for test_uart: stimulus queues expected status words, a negedge monitor compares them.
`timescale 1ns/1ps
module tb_test_uart;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rd_uart = 1'b0;
    logic glitch_m = 1'b0;
    logic rx_fem, rx_m, tx_fem, tx_m;
    logic tx_full_fem, tx_full_m, rx_full_fem, rx_full_m, rx_empty_fem, rx_empty_m;
    logic led0, led1, led2, led3, led4, led5, led6, led7;

    always #5 clk = ~clk;

    assign rx_fem = tx_fem;
    assign rx_m   = tx_m & ~glitch_m;

    test_uart #(.DBIT(8), .SB_TICK(16), .DVSR(1), .DVSR_BIT(1), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .rd_uart(rd_uart), .rx_fem(rx_fem), .rx_m(rx_m),
        .tx_fem(tx_fem), .tx_m(tx_m), .tx_full_fem(tx_full_fem), .tx_full_m(tx_full_m),
        .rx_full_fem(rx_full_fem), .rx_full_m(rx_full_m),
        .rx_empty_fem(rx_empty_fem), .rx_empty_m(rx_empty_m),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3),
        .led4(led4), .led5(led5), .led6(led6), .led7(led7)
    );

    // {tx_fem, tx_m, tx_full_fem, tx_full_m, rx_full_fem, rx_full_m, rx_empty_fem, rx_empty_m, leds}
    logic [15:0] obs;
    assign obs = {tx_fem, tx_m, tx_full_fem, tx_full_m, rx_full_fem, rx_full_m,
                  rx_empty_fem, rx_empty_m, led7, led6, led5, led4, led3, led2, led1, led0};

    typedef struct {
        logic [95:0] name;
        logic [15:0] want;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [15:0] pop_exp [4] = '{16'hC0AA, 16'hC00F, 16'hC0F0, 16'hC300};

    task automatic expect_obs(input logic [95:0] name, input logic [15:0] want, input logic [15:0] mask);
        exp_t e;
        e.name = name;
        e.want = want;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic check_val(input logic [95:0] name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %0s: got %0d want %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if ((obs & e.mask) !== (e.want & e.mask)) begin
                n_miss++;
                $display("FAIL %0s: got %h want %h (mask %h)", e.name, obs & e.mask, e.want & e.mask, e.mask);
            end
        end
    end

    // Called on the cycle reset is released: frame should start 2 edges later (load, then pop).
    task automatic check_frame(input logic [7:0] pat);
        int   waited;
        logic bit_exp;
        waited = 0;
        while (tx_fem !== 1'b0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val("tx_start_lat", waited, 2);
        for (int i = 0; i < 160; i++) begin
            if (i < 16)
                bit_exp = 1'b0;
            else if (i < 144)
                bit_exp = pat[(i - 16) / 16];
            else
                bit_exp = 1'b1;
            expect_obs("tx_fem_frame", {bit_exp, 15'b0}, 16'h8000);
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        reset = 1'b1;
        @(posedge clk); #1;
        expect_obs("reset_state", 16'hC300, 16'hFFFF);
        @(posedge clk); #1;
        reset = 1'b0;
        check_frame(8'h55);

        repeat (1700) @(posedge clk);
        #1;
        expect_obs("after_load", 16'hCC55, 16'hFFFF);

        for (int k = 0; k < 4; k++) begin
            repeat (9) @(posedge clk);
            #1 rd_uart = 1'b1;
            @(posedge clk); #1;
            rd_uart = 1'b0;
            expect_obs("rd_pop", pop_exp[k], 16'hFFFF);
        end

        repeat (9) @(posedge clk);
        #1 rd_uart = 1'b1;
        @(posedge clk); #1;
        rd_uart = 1'b0;
        expect_obs("rd_empty", 16'hC300, 16'hFFFF);

        @(posedge clk); #1;
        glitch_m = 1'b1;
        @(posedge clk); #1;
        glitch_m = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        expect_obs("glitch_m", 16'hC300, 16'hFFFF);

        // Restart, then reset again during data bit 1 (a 0 bit of 0x55).
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        expect_obs("pre_reset", 16'h0000, 16'h8000);
        @(posedge clk); #1;
        reset = 1'b1;
        expect_obs("mid_reset", 16'hC300, 16'hFFFF);
        @(posedge clk); #1;
        reset = 1'b0;
        check_frame(8'h55);

        repeat (1700) @(posedge clk);
        #1;
        expect_obs("reload", 16'hCC55, 16'hFFFF);

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
